// File: rtl/cpu_pkg.sv
// cpu_pkg: shared forwarding encodings, stage record type and tnew helpers
package cpu_pkg;
  localparam int TNEW_W = 2;
  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E = 2'd1;
  localparam logic [1:0] FWD_M = 2'd2;
  localparam logic [1:0] FWD_W = 2'd3;
  localparam logic [TNEW_W-1:0] TUSE_NONE = '1;
  typedef struct packed {
    logic valid;
    logic [4:0] a3;
    logic [TNEW_W-1:0] tnew;
  } stage_rec_t;
  function automatic logic [TNEW_W-1:0] dec_sat(input logic [TNEW_W-1:0] t);
    return (t == '0) ? t : t - 1'b1;
  endfunction
endpackage

// File: rtl/grf_hazard_scoreboard_if.sv
// grf_hazard_scoreboard_if: D-stage request and hazard/forwarding response bundle
interface grf_hazard_scoreboard_if #(
  parameter int TW = 2,
  parameter int CNTW = 32
);
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic [4:0] d_a3;
  logic d_wen;
  logic [TW-1:0] d_tnew;
  logic d_is_md;
  logic md_busy;
  logic flush;
  logic stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic [CNTW-1:0] stall_cnt;
  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_wen, d_tnew, d_is_md, md_busy, flush,
    input stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );
  modport slave (
    input d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_wen, d_tnew, d_is_md, md_busy, flush,
    output stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );
endinterface

// File: rtl/hazard_port_check.sv
// hazard_port_check: stall and forwarding-source decision for one D-stage read port
module hazard_port_check
  import cpu_pkg::*;
#(
  parameter int TW = 2
) (
  input  logic [4:0]    d_p,
  input  logic [TW-1:0] tuse,
  input  stage_rec_t    e_rec,
  input  stage_rec_t    m_rec,
  input  logic          w_valid,
  input  logic [4:0]    w_a3,
  output logic          haz,
  output logic [1:0]    sel
);
  logic e_hit, m_hit, w_hit;
  // m_rec.tnew was already decremented on the E->M shift, so it is the M-stage remaining latency
  always_comb begin
    e_hit = e_rec.valid && e_rec.a3 == d_p && d_p != '0;
    m_hit = m_rec.valid && m_rec.a3 == d_p && d_p != '0;
    w_hit = w_valid && w_a3 == d_p && d_p != '0;
    haz = tuse != TUSE_NONE && ((e_hit && e_rec.tnew > tuse) || (m_hit && m_rec.tnew > tuse));
    sel = e_hit ? (e_rec.tnew == '0 ? FWD_E : FWD_GRF) :
          m_hit ? (m_rec.tnew == '0 ? FWD_M : FWD_GRF) :
          w_hit ? FWD_W : FWD_GRF;
  end
endmodule

// File: rtl/grf_hazard_scoreboard.sv
// grf_hazard_scoreboard: tracks E/M/W destination writes, raises D stall and picks forwarding sources
module grf_hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int TW = TNEW_W,
  parameter int CNTW = 32
) (
  input logic clk,
  input logic reset,
  grf_hazard_scoreboard_if.slave bus
);
  stage_rec_t e_q, e_d, m_q, m_d, w_q, w_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic rs_haz, rt_haz, stall;
  hazard_port_check #(.TW(TW)) u_rs (
    .d_p(bus.d_rs), .tuse(bus.d_tuse_rs), .e_rec(e_q), .m_rec(m_q),
    .w_valid(w_q.valid), .w_a3(w_q.a3), .haz(rs_haz), .sel(bus.fwd_rs_sel)
  );
  hazard_port_check #(.TW(TW)) u_rt (
    .d_p(bus.d_rt), .tuse(bus.d_tuse_rt), .e_rec(e_q), .m_rec(m_q),
    .w_valid(w_q.valid), .w_a3(w_q.a3), .haz(rt_haz), .sel(bus.fwd_rt_sel)
  );
  // stall dominates: a stalled or flushed D never reaches E, so E takes a bubble
  always_comb begin
    stall = rs_haz || rt_haz || (bus.d_is_md && bus.md_busy);
    w_d = m_q;
    m_d = e_q;
    m_d.tnew = dec_sat(e_q.tnew);
    e_d = (stall || bus.flush) ? '0 :
          stage_rec_t'{valid: bus.d_wen && bus.d_a3 != '0, a3: bus.d_a3, tnew: bus.d_tnew};
    cnt_d = cnt_q + CNTW'(stall);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
      cnt_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.stall = stall;
  assign bus.stall_cnt = cnt_q;
endmodule

// File: doc/grf_hazard_scoreboard.md
Name: grf_hazard_scoreboard

Overview:
- Tracks in-flight GRF destination writes through the E, M and W stages of the 5-stage pipeline.
- Each cycle, decides whether the D-stage instruction must stall.
- Selects the forwarding source for each D-stage read port (rs/rt): GRF, E, M or W.
- Sits beside the GRF and sequences the GRF as a shared resource between in-flight writers and the D-stage reader.

Parameters:
- TW, 2, width of Tnew/Tuse fields.
- CNTW, 32, width of stall performance counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- d_rs  in  5  D-stage rs address.
- d_rt  in  5  D-stage rt address.
- d_tuse_rs  in  TW  cycles until rs is needed, relative to D; 3 means rs unused.
- d_tuse_rt  in  TW  cycles until rt is needed, relative to D; 3 means rt unused.
- d_a3  in  5  destination of D-stage instruction.
- d_wen  in  1  D-stage instruction writes GRF.
- d_tnew  in  TW  cycles after entering E until result is available.
- d_is_md  in  1  D-stage instruction uses mult/div unit.
- md_busy  in  1  mult/div unit busy.
- flush  in  1  kill D-to-E transfer (bubble into E) this cycle.
- stall  out  1  freeze PC/F/D, bubble into E.
- fwd_rs_sel  out  2  0 GRF, 1 E, 2 M, 3 W.
- fwd_rt_sel  out  2  same encoding as fwd_rs_sel.
- stall_cnt  out  CNTW  number of stall cycles since reset.

Behaviour:
- Internal state: three stage records E, M, W. Each record holds {valid, a3[4:0], tnew[TW-1:0]}.
- Reset: asserting reset low clears all records (valid=0, a3=0, tnew=0) and stall_cnt=0, asynchronously. Outputs are then stall=0 and fwd_*_sel=0. Reset mid-stall discards all in-flight records.
- Record insertion: a record is valid only if wen=1 and a3!=0. Writes to $0 are never tracked.
- Per rising edge:
  - W <= M.
  - M <= E with tnew = (E.tnew==0) ? 0 : E.tnew-1 (saturating).
  - E <= bubble if stall or flush; otherwise {d_wen && d_a3!=0, d_a3, d_tnew}.
- W.tnew is always treated as 0.
- Stall (combinational from current state and D inputs), for port p in {rs, rt}:
  - p_hazE = E.valid && E.a3==d_p && d_p!=0 && E.tnew > d_tuse_p.
  - p_hazM = M.valid && M.a3==d_p && d_p!=0 && (M.tnew dec-saturated) > d_tuse_p. M.tnew is compared after the pending decrement, i.e. the M-stage remaining latency.
  - stall = rs_hazE | rs_hazM | rt_hazE | rt_hazM | (d_is_md && md_busy).
  - tuse==3 never causes a stall: tnew max is 3, and the strict > rule never fires.
- Forwarding: select the youngest matching stage among E, M, W with valid, a3==d_p, d_p!=0.
  - If that youngest match is not ready (tnew!=0), sel=0. Stall covers that case, or the value is not yet needed.
  - An older stage is never selected when a younger stage matches.
  - d_p==0 always gives sel=0.
- W forwarding is mandatory: the GRF has no write-through, so a D read in the same cycle as a W write sees the old value.
- stall_cnt increments by 1 on each edge where stall=1. It wraps at 2^CNTW.
- Simultaneous flush and stall: E gets a bubble and stall stays asserted (stall dominates the D hold).

Decomposition:
- Shared package cpu_pkg:
  - FWD_GRF/FWD_E/FWD_M/FWD_W constants.
  - TUSE_NONE=3.
  - stage_rec_t struct {valid, a3, tnew}.
- One sub-module, hazard_port_check: per-port combinational match/stall/select logic. It is instantiated twice (rs, rt).
- The top level holds the stage records, the shift logic and the counter.

Test Plan:
- Reset low mid-traffic (E holds a3=5, tnew=2) → stall=0, fwd sel=0, stall_cnt=0 immediately; after release, D reads rs=5 with sel=0.
- Load-use: cycle0 D{a3=8, wen, tnew=2}; cycle1 D{rs=8, tuse_rs=0} → stall=1 for 2 cycles; then fwd_rs_sel=W(3), stall_cnt=2.
- ALU back-to-back: D{a3=9, tnew=1} then D{rs=9, tuse_rs=1} → no stall; next cycle the record is in M with tnew 0, fwd_rs_sel=2.
- Write to $0: D{a3=0, wen, tnew=2} then D{rs=0, tuse_rs=0} → stall=0, fwd_rs_sel=0.
- Youngest wins: E{a3=4, tnew=0}, M{a3=4, tnew=0}, D{rt=4} → fwd_rt_sel=1; if E.tnew=1 and tuse_rt=1 → sel=0, stall=0.
- md_busy=1, d_is_md=1 for 5 cycles → stall=1 for exactly 5 cycles, E receives bubbles, stall_cnt=5.
